asm_stream_encoder: RTL and testbench

- Hardware successor to the software assembler: accepts pre-tokenised instructions on a valid/ready stream and encodes them into instruction words.
- Writes each word sequentially into the instruction-memory write port of the pipelined processor.
- Parametrised in register-index width, instruction width and program depth.
- Adds immediate range checking, sticky error reporting, a full/done protocol and a two-stage pipeline.

---
 rtl/asm_pkg.sv | 74 +++++++
 rtl/asm_field_pack.sv | 100 ++++++++++
 rtl/asm_stream_encoder.sv | 207 ++++++++++++++++++++
 tb/tb_asm_stream_encoder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asm_pkg.sv
// Shared types and constants for the streaming instruction encoder: mnemonics, FSM
// states, opcode/func codes, error codes and the immediate-field bounds helper.
package asm_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        ADDI = 4'd4,
        SUBI = 4'd5,
        LD   = 4'd6,
        ST   = 4'd7,
        JMP  = 4'd8,
        BEQ  = 4'd9,
        BNE  = 4'd10
    } mnem_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_LS   = 3'd2,
        IMM_BR   = 3'd3,
        IMM_JMP  = 3'd4
    } imm_cls_e;

    localparam logic [3:0] OP_R   = 4'b0001;
    localparam logic [3:0] OP_I   = 4'b0010;
    localparam logic [3:0] OP_LD  = 4'b0011;
    localparam logic [3:0] OP_ST  = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;

    localparam logic [3:0] FN_ADD  = 4'b0001;
    localparam logic [3:0] FN_SUB  = 4'b0010;
    localparam logic [3:0] FN_AND  = 4'b0100;
    localparam logic [3:0] FN_OR   = 4'b1000;
    localparam logic [3:0] FN_ADDI = 4'b0001;
    localparam logic [3:0] FN_SUBI = 4'b0010;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;
    localparam logic [1:0] ERR_MNEM  = 2'b11;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } imm_bounds_t;

    // Inclusive [hi:lo] bit range of the immediate field for one instruction class.
    function automatic imm_bounds_t imm_bounds(input imm_cls_e cls, input int reg_w,
                                               input int instr_w);
        imm_bounds_t b;
        b.hi = 16'(instr_w - 1);
        b.lo = 16'(4 + 2 * reg_w);
        case (cls)
            IMM_I:   b.hi = 16'(instr_w - 5);
            IMM_LS:  b.lo = 16'(4 + reg_w);
            IMM_JMP: b.lo = 16'd4;
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/asm_field_pack.sv
// Combinational instruction packer: mnemonic, register operands and immediate in,
// encoded word out, with immediate range and mnemonic legality flags.
module asm_field_pack
    import asm_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int INSTR_W = 24,
    parameter int IMM_W   = 33
) (
    input  mnem_e                    mnem,
    input  logic [REG_W-1:0]         r1,
    input  logic [REG_W-1:0]         r2,
    input  logic [REG_W-1:0]         r3,
    input  logic signed [IMM_W-1:0]  imm,
    output logic [INSTR_W-1:0]       word,
    output logic                     range_ok,
    output logic                     legal
);

    localparam imm_bounds_t B_I   = imm_bounds(IMM_I,   REG_W, INSTR_W);
    localparam imm_bounds_t B_LS  = imm_bounds(IMM_LS,  REG_W, INSTR_W);
    localparam imm_bounds_t B_BR  = imm_bounds(IMM_BR,  REG_W, INSTR_W);
    localparam imm_bounds_t B_JMP = imm_bounds(IMM_JMP, REG_W, INSTR_W);

    localparam int I_LO   = int'(B_I.lo);
    localparam int I_W    = int'(B_I.hi) - int'(B_I.lo) + 1;
    localparam int LS_LO  = int'(B_LS.lo);
    localparam int LS_W   = int'(B_LS.hi) - int'(B_LS.lo) + 1;
    localparam int BR_LO  = int'(B_BR.lo);
    localparam int BR_W   = int'(B_BR.hi) - int'(B_BR.lo) + 1;
    localparam int JMP_LO = int'(B_JMP.lo);
    localparam int JMP_W  = int'(B_JMP.hi) - int'(B_JMP.lo) + 1;

    localparam int R1_LO = 4;
    localparam int R2_LO = 4 + REG_W;
    localparam int R3_LO = 4 + 2 * REG_W;

    // Fits in w-bit two's complement iff everything above bit w-2 is pure sign.
    function automatic logic fits(input logic signed [IMM_W-1:0] v, input int w);
        logic signed [IMM_W-1:0] t;
        if (w >= IMM_W) return 1'b1;
        t = v >>> (w - 1);
        return (t == '0) || (t == '1);
    endfunction

    function automatic logic [3:0] func_of(input mnem_e m);
        case (m)
            ADD:     return FN_ADD;
            SUB:     return FN_SUB;
            AND:     return FN_AND;
            OR:      return FN_OR;
            ADDI:    return FN_ADDI;
            SUBI:    return FN_SUBI;
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        legal    = 1'b1;
        case (mnem)
            ADD, SUB, AND, OR: begin
                word[3:0]             = OP_R;
                word[R1_LO +: REG_W]  = r1;
                word[R2_LO +: REG_W]  = r2;
                word[R3_LO +: REG_W]  = r3;
                word[INSTR_W-1 -: 4]  = func_of(mnem);
            end
            ADDI, SUBI: begin
                word[3:0]             = OP_I;
                word[R1_LO +: REG_W]  = r1;
                word[R2_LO +: REG_W]  = r2;
                word[I_LO +: I_W]     = imm[I_W-1:0];
                word[INSTR_W-1 -: 4]  = func_of(mnem);
                range_ok              = fits(imm, I_W);
            end
            LD, ST: begin
                word[3:0]             = (mnem == LD) ? OP_LD : OP_ST;
                word[R1_LO +: REG_W]  = r1;
                word[LS_LO +: LS_W]   = imm[LS_W-1:0];
                range_ok              = fits(imm, LS_W);
            end
            BEQ, BNE: begin
                word[3:0]             = (mnem == BEQ) ? OP_BEQ : OP_BNE;
                word[R1_LO +: REG_W]  = r1;
                word[R2_LO +: REG_W]  = r2;
                word[BR_LO +: BR_W]   = imm[BR_W-1:0];
                range_ok              = fits(imm, BR_W);
            end
            JMP: begin
                word[3:0]             = OP_JMP;
                word[JMP_LO +: JMP_W] = imm[JMP_W-1:0];
                range_ok              = fits(imm, JMP_W);
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/asm_stream_encoder.sv
// Streaming assembler: accepts tokens on valid/ready, encodes them in a two-stage
// pipeline and writes words to instruction memory. Option: ASM_BRANCH_REL_EN.
module asm_stream_encoder
    import asm_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int INSTR_W    = 24,
    parameter int PROG_DEPTH = 256,
    parameter int IMM_IN_W   = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  mnem_e                           in_mnem,
    input  logic [REG_W-1:0]                in_r1,
    input  logic [REG_W-1:0]                in_r2,
    input  logic [REG_W-1:0]                in_r3,
    input  logic signed [IMM_IN_W-1:0]      in_imm,
    input  logic                            in_last,
    output logic                            mem_we,
    output logic [$clog2(PROG_DEPTH)-1:0]   mem_addr,
    output logic [INSTR_W-1:0]              mem_wdata,
    output logic                            done,
    output logic [$clog2(PROG_DEPTH):0]     count,
    output logic                            err,
    output logic [1:0]                      err_code,
    output logic [$clog2(PROG_DEPTH)-1:0]   err_addr
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = IMM_IN_W + 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       acc_q, acc_d;
    logic                last_seen_q, last_seen_d;
    logic                vld_p1_q, vld_p1_d;
    logic                last_p1_q, last_p1_d;
    logic [INSTR_W-1:0]  word_p1_q, word_p1_d;
    logic [AW-1:0]       addr_p1_q, addr_p1_d;
    logic                mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic                last_p2_q, last_p2_d;
    logic                done_q, done_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [AW-1:0]       err_addr_q, err_addr_d;

    logic                full;
    logic                accept;
    logic signed [IW-1:0] imm_eff;
    logic [INSTR_W-1:0]  pk_word;
    logic                pk_range_ok;
    logic                pk_legal;

    // acc_q counts accepted tokens, so it is also the address the current token will get.
    assign full     = (acc_q == CW'(PROG_DEPTH));
    assign in_ready = (state_q == S_RUN) && !full && !last_seen_q;
    assign accept   = in_valid && in_ready && !start;

`ifdef ASM_BRANCH_REL_EN
    always_comb begin
        imm_eff = {in_imm[IMM_IN_W-1], in_imm};
        if (in_mnem == JMP || in_mnem == BEQ || in_mnem == BNE)
            imm_eff = imm_eff - {{(IW-CW){1'b0}}, acc_q};
    end
`else
    assign imm_eff = {in_imm[IMM_IN_W-1], in_imm};
`endif

    asm_field_pack #(
        .REG_W   (REG_W),
        .INSTR_W (INSTR_W),
        .IMM_W   (IW)
    ) u_pack (
        .mnem     (in_mnem),
        .r1       (in_r1),
        .r2       (in_r2),
        .r3       (in_r3),
        .imm      (imm_eff),
        .word     (pk_word),
        .range_ok (pk_range_ok),
        .legal    (pk_legal)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        last_seen_d = last_seen_q;
        vld_p1_d    = 1'b0;
        last_p1_d   = 1'b0;
        word_p1_d   = word_p1_q;
        addr_p1_d   = addr_p1_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        last_p2_d   = 1'b0;
        count_d     = count_q;
        done_d      = done_q | (mem_we_q & last_p2_q);
        err_d       = err_q;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;

        // Stage 2: whatever made it into stage 1 is written, even if an error follows.
        if (vld_p1_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_p1_q;
            mem_wdata_d = word_p1_q;
            last_p2_d   = last_p1_q;
            count_d     = count_q + CW'(1);
        end

        // Stage 1: a failing token never enters the pipeline.
        if (state_q == S_RUN) begin
            if (accept) begin
                if (!pk_legal || !pk_range_ok) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = pk_legal ? ERR_RANGE : ERR_MNEM;
                    err_addr_d = acc_q[AW-1:0];
                end else begin
                    vld_p1_d  = 1'b1;
                    last_p1_d = in_last;
                    word_p1_d = pk_word;
                    addr_p1_d = acc_q[AW-1:0];
                    acc_d     = acc_q + CW'(1);
                    if (in_last) begin
                        last_seen_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end else if (in_valid && full && !last_seen_q) begin
                state_d    = S_ERR;
                err_d      = 1'b1;
                err_code_d = ERR_OVF;
                err_addr_d = acc_q[AW-1:0];
            end
        end

        if (start) begin
            state_d     = S_RUN;
            acc_d       = '0;
            last_seen_d = 1'b0;
            vld_p1_d    = 1'b0;
            mem_we_d    = 1'b0;
            count_d     = '0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            err_code_d  = ERR_NONE;
            err_addr_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            last_seen_q <= 1'b0;
            vld_p1_q    <= 1'b0;
            last_p1_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            last_p2_q   <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            last_seen_q <= last_seen_d;
            vld_p1_q    <= vld_p1_d;
            last_p1_q   <= last_p1_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            last_p2_q   <= last_p2_d;
            done_q      <= done_d;
            count_q     <= count_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Stage-1 payload is qualified by vld_p1_q and needs no reset.
    always_ff @(posedge clk) begin
        word_p1_q <= word_p1_d;
        addr_p1_q <= addr_p1_d;
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_asm_stream_encoder.sv
// Bench for asm_stream_encoder: single-token vector table plus multi-token sequences,
// with a write scoreboard per instance (default depth and PROG_DEPTH=4).
module tb_asm_stream_encoder;
    import asm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic start4 = 1'b0, in_valid4 = 1'b0;
    mnem_e in_mnem = ADD;
    logic [3:0] in_r1 = '0, in_r2 = '0, in_r3 = '0;
    logic signed [31:0] in_imm = '0;

    logic in_ready, mem_we, done, err;
    logic [7:0] mem_addr, err_addr;
    logic [23:0] mem_wdata;
    logic [8:0] count;
    logic [1:0] err_code;

    logic in_ready4, mem_we4, done4, err4;
    logic [1:0] mem_addr4, err_addr4;
    logic [23:0] mem_wdata4;
    logic [2:0] count4;
    logic [1:0] err_code4;

    asm_stream_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_r1(in_r1), .in_r2(in_r2), .in_r3(in_r3), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .count(count), .err(err), .err_code(err_code), .err_addr(err_addr)
    );

    asm_stream_encoder #(.PROG_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_mnem(in_mnem), .in_r1(in_r1), .in_r2(in_r2), .in_r3(in_r3), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .done(done4), .count(count4), .err(err4), .err_code(err_code4), .err_addr(err_addr4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] word;
    } wexp_t;

    typedef struct {
        mnem_e              m;
        logic [3:0]         r1, r2, r3;
        logic signed [31:0] imm;
        logic               ok;
        logic [1:0]         code;
        logic [23:0]        word;
    } vec_t;

    wexp_t exp_q[$];
    wexp_t exp4_q[$];
    wexp_t e_m, e_m4;
    vec_t  vt[$];
    int checks = 0;
    int errors = 0;

`ifdef ASM_BRANCH_REL_EN
    localparam logic [23:0] BEQ_AT3_WORD = 24'h007218;
`else
    localparam logic [23:0] BEQ_AT3_WORD = 24'h00A218;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=0x%0h required=none", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input mnem_e m, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic signed [31:0] imm, input logic last);
        int n;
        n = 0;
        in_mnem = m; in_r1 = a; in_r2 = b; in_r3 = c; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) fail_now("send_timeout", 64'(n));
        else tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic addv(input mnem_e m, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic signed [31:0] imm,
                        input logic ok, input logic [1:0] code, input logic [23:0] word);
        vec_t v;
        v.m = m; v.r1 = a; v.r2 = b; v.r3 = c; v.imm = imm;
        v.ok = ok; v.code = code; v.word = word;
        vt.push_back(v);
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) fail_now("unexpected_write", 64'(mem_wdata));
            else begin
                e_m = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e_m.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e_m.word));
            end
        end
        if (mem_we4 === 1'b1) begin
            if (exp4_q.size() == 0) fail_now("unexpected_write4", 64'(mem_wdata4));
            else begin
                e_m4 = exp4_q.pop_front();
                chk("wr4_addr", 64'(mem_addr4), 64'(e_m4.addr));
                chk("wr4_data", 64'(mem_wdata4), 64'(e_m4.word));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        addv(ADD,  1, 2, 3,  3,        1, 2'b00, 24'h103211);
        addv(SUB,  15, 0, 9, 0,        1, 2'b00, 24'h2090F1);
        addv(AND,  3, 4, 5,  0,        1, 2'b00, 24'h405431);
        addv(OR,   7, 8, 10, 0,        1, 2'b00, 24'h80A871);
        addv(ADDI, 4, 5, 0,  -3,       1, 2'b00, 24'h1FD542);
        addv(SUBI, 1, 2, 0,  127,      1, 2'b00, 24'h27F212);
        addv(SUBI, 0, 0, 0,  -128,     1, 2'b00, 24'h280002);
        addv(ADDI, 0, 0, 0,  128,      0, 2'b01, 24'h0);
        addv(ADDI, 0, 0, 0,  -129,     0, 2'b01, 24'h0);
        addv(LD,   6, 0, 0,  300,      1, 2'b00, 24'h012C63);
        addv(ST,   2, 0, 0,  -1,       1, 2'b00, 24'hFFFF2C);
        addv(LD,   0, 0, 0,  32767,    1, 2'b00, 24'h7FFF03);
        addv(ST,   0, 0, 0,  32768,    0, 2'b01, 24'h0);
        addv(JMP,  0, 0, 0,  5,        1, 2'b00, 24'h000054);
        addv(JMP,  0, 0, 0,  -524288,  1, 2'b00, 24'h800004);
        addv(JMP,  0, 0, 0,  524288,   0, 2'b01, 24'h0);
        addv(BEQ,  1, 2, 0,  10,       1, 2'b00, 24'h00A218);
        addv(BNE,  3, 1, 0,  -2048,    1, 2'b00, 24'h800139);
        addv(BNE,  0, 0, 0,  2048,     0, 2'b01, 24'h0);
        addv(mnem_e'(4'd13), 0, 0, 0, 0, 0, 2'b11, 24'h0);

        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_mem_we", 64'(mem_we), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_mem_wdata", 64'(mem_wdata), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_err_code", 64'(err_code), 0);
        chk("rst_err_addr", 64'(err_addr), 0);
        chk("rst_count4", 64'(count4), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_not_ready", 64'(in_ready), 0);

        for (int i = 0; i < vt.size(); i++) begin
            pulse_start();
            if (vt[i].ok) exp_q.push_back('{8'd0, vt[i].word});
            send(vt[i].m, vt[i].r1, vt[i].r2, vt[i].r3, vt[i].imm, 1'b1);
            repeat (3) tick();
            chk($sformatf("v%0d_done", i), 64'(done), 64'(vt[i].ok));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(!vt[i].ok));
            chk($sformatf("v%0d_err_code", i), 64'(err_code), 64'(vt[i].code));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].ok));
            chk($sformatf("v%0d_err_addr", i), 64'(err_addr), 0);
        end

        // Back-to-back ADDI then LD with in_last.
        pulse_start();
        exp_q.push_back('{8'd0, 24'h1FD542});
        exp_q.push_back('{8'd1, 24'h012C63});
        send(ADDI, 4, 5, 0, -3, 1'b0);
        send(LD, 6, 0, 0, 300, 1'b1);
        chk("b2b_ready_after_last", 64'(in_ready), 0);
        tick();
        chk("b2b_done_early", 64'(done), 0);
        tick();
        chk("b2b_done", 64'(done), 1);
        chk("b2b_count", 64'(count), 2);

        // Range error on the third token: first two still land.
        pulse_start();
        chk("start_clears_done", 64'(done), 0);
        exp_q.push_back('{8'd0, 24'h103211});
        exp_q.push_back('{8'd1, 24'h100001});
        send(ADD, 1, 2, 3, 0, 1'b0);
        send(ADD, 0, 0, 0, 0, 1'b0);
        send(ADDI, 1, 1, 0, 200, 1'b0);
        chk("rng_err", 64'(err), 1);
        chk("rng_err_code", 64'(err_code), 1);
        chk("rng_err_addr", 64'(err_addr), 2);
        chk("rng_ready", 64'(in_ready), 0);
        repeat (3) tick();
        chk("rng_ready_hold", 64'(in_ready), 0);
        chk("rng_count", 64'(count), 2);
        pulse_start();
        chk("rng_restart_ready", 64'(in_ready), 1);
        chk("rng_restart_err", 64'(err), 0);

        // Branch at address 3.
        exp_q.push_back('{8'd0, 24'h103211});
        exp_q.push_back('{8'd1, 24'h103211});
        exp_q.push_back('{8'd2, 24'h103211});
        exp_q.push_back('{8'd3, BEQ_AT3_WORD});
        send(ADD, 1, 2, 3, 0, 1'b0);
        send(ADD, 1, 2, 3, 0, 1'b0);
        send(ADD, 1, 2, 3, 0, 1'b0);
        send(BEQ, 1, 2, 0, 10, 1'b1);
        repeat (3) tick();
        chk("beq3_done", 64'(done), 1);
        chk("beq3_count", 64'(count), 4);

        // Reset with a token in flight: it must vanish.
        pulse_start();
        send(ADD, 1, 2, 3, 0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_we", 64'(mem_we), 0);
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_done", 64'(done), 0);
        chk("mid_rst_err", 64'(err), 0);
        chk("mid_rst_wdata", 64'(mem_wdata), 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_count", 64'(count), 0);
        chk("post_rst_ready", 64'(in_ready), 0);
        pulse_start();
        exp_q.push_back('{8'd0, 24'h000054});
        send(JMP, 0, 0, 0, 5, 1'b1);
        repeat (3) tick();
        chk("jmp_done", 64'(done), 1);
        chk("jmp_count", 64'(count), 1);

        // Overflow on the depth-4 instance with in_valid held.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        in_mnem = ADD; in_r1 = 1; in_r2 = 2; in_r3 = 3; in_imm = 0; in_last = 1'b0;
        in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                chk($sformatf("ovf_ready_%0d", i), 64'(in_ready4), 1);
                exp4_q.push_back('{8'(i), 24'h103211});
            end
            tick();
            if (i == 3) chk("ovf_ready_full", 64'(in_ready4), 0);
        end
        in_valid4 = 1'b0;
        chk("ovf_err", 64'(err4), 1);
        chk("ovf_err_code", 64'(err_code4), 2);
        repeat (2) tick();
        chk("ovf_count", 64'(count4), 4);
        chk("ovf_done", 64'(done4), 0);

        repeat (3) tick();
        chk("sb_drain", 64'(exp_q.size()), 0);
        chk("sb4_drain", 64'(exp4_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
